// File: rtl/psum_accumulator_if.sv
// rtl/psum_accumulator_if.sv - beat/result bus between the MAC outputs and the partial-sum accumulator
//
// Purpose: groups the input beat handshake, the flush control and the result
// pulse of psum_accumulator into one bundle.
// Signals:
//   in_valid  - beat qualifier for in_data
//   in_data   - NUM_IN packed signed lanes, lane i at [i*DATAWIDTH +: DATAWIDTH]
//   flush     - abort the current accumulation
//   out_valid - one-cycle result pulse
//   out_data  - signed result (held between pulses)
//   out_sat   - result was clamped
//   busy      - partial sum in flight
// Modports: master drives beats (producer side), slave is the accumulator.
interface psum_accumulator_if #(
  parameter int DATAWIDTH = 8,
  parameter int NUM_IN    = 3,
  parameter int OUT_WIDTH = 10
);
  logic                        in_valid;
  logic [NUM_IN*DATAWIDTH-1:0] in_data;
  logic                        flush;
  logic                        out_valid;
  logic [OUT_WIDTH-1:0]        out_data;
  logic                        out_sat;
  logic                        busy;

  modport master (
    output in_valid, in_data, flush,
    input  out_valid, out_data, out_sat, busy
  );

  modport slave (
    input  in_valid, in_data, flush,
    output out_valid, out_data, out_sat, busy
  );
endinterface

// File: rtl/psum_accumulator.sv
// rtl/psum_accumulator.sv - registered NUM_IN-lane adder feeding an ACC_LEN-beat accumulator with ReLU/saturation
//
// Purpose: stage 1 registers the signed sum of NUM_IN lanes of each valid beat;
// stage 2 accumulates ACC_LEN such sums and emits one post-processed result
// (optional ReLU, then clamp or truncate to OUT_WIDTH) as a one-cycle pulse.
// Ports:
//   clk - single clock, posedge
//   rst - synchronous active-high reset, overrides everything
//   bus - psum_accumulator_if slave: in_valid/in_data/flush in,
//         out_valid/out_data/out_sat/busy out
module psum_accumulator #(
  parameter int DATAWIDTH = 8,
  parameter int NUM_IN    = 3,
  parameter int ACC_LEN   = 4,
  parameter int OUT_WIDTH = 10,
  parameter bit SAT_EN    = 1'b1,
  parameter bit RELU_EN   = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  psum_accumulator_if.slave  bus
);

  localparam int SUM_W = DATAWIDTH + $clog2(NUM_IN);
  localparam int ACC_W = SUM_W + $clog2(ACC_LEN);
  localparam int CNT_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(ACC_LEN - 1);
  localparam longint OUT_MAX_L = (longint'(1) <<< (OUT_WIDTH - 1)) - 1;
  localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'(OUT_MAX_L);
  localparam logic signed [ACC_W-1:0] OUT_MIN = ACC_W'(-OUT_MAX_L - 1);

  logic                        s1_valid_q;
  logic signed [SUM_W-1:0]     s1_sum_q;
  logic signed [ACC_W-1:0]     acc_q;
  logic [CNT_W-1:0]            beat_cnt_q;
  logic                        out_valid_q;
  logic [OUT_WIDTH-1:0]        out_data_q;
  logic                        out_sat_q;

  logic signed [SUM_W-1:0]     lane_sum_d;
  logic signed [ACC_W-1:0]     acc_base_d;
  logic signed [ACC_W-1:0]     total_d;
  logic signed [ACC_W-1:0]     relu_d;
  logic [OUT_WIDTH-1:0]        post_data_d;
  logic                        post_sat_d;
  logic                        last_beat_d;

  // Lanes are sign-extended to SUM_W before adding, so the sum never wraps.
  always_comb begin
    lane_sum_d = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      lane_sum_d = lane_sum_d + SUM_W'($signed(bus.in_data[i*DATAWIDTH +: DATAWIDTH]));
    end
  end

  // The first beat of a group starts from zero rather than the stale acc.
  always_comb begin
    acc_base_d  = (beat_cnt_q == '0) ? '0 : acc_q;
    total_d     = acc_base_d + ACC_W'(s1_sum_q);
    last_beat_d = (beat_cnt_q == LAST_BEAT);
  end

  // ReLU first, then clamp (out_sat flags it) or plain truncation.
  always_comb begin
    relu_d      = (RELU_EN && (total_d < 0)) ? '0 : total_d;
    post_data_d = relu_d[OUT_WIDTH-1:0];
    post_sat_d  = 1'b0;
    if (SAT_EN) begin
      if (relu_d > OUT_MAX) begin
        post_data_d = OUT_MAX[OUT_WIDTH-1:0];
        post_sat_d  = 1'b1;
      end else if (relu_d < OUT_MIN) begin
        post_data_d = OUT_MIN[OUT_WIDTH-1:0];
        post_sat_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_sum_q    <= '0;
      acc_q       <= '0;
      beat_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else if (bus.flush) begin
      // Drops the beat in stage 1, the beat arriving now, and any result
      // that this edge would have emitted; out_data keeps its last value.
      s1_valid_q  <= 1'b0;
      acc_q       <= '0;
      beat_cnt_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      s1_valid_q  <= bus.in_valid;
      if (bus.in_valid) begin
        s1_sum_q <= lane_sum_d;
      end
      out_valid_q <= 1'b0;
      if (s1_valid_q) begin
        if (last_beat_d) begin
          out_valid_q <= 1'b1;
          out_data_q  <= post_data_d;
          out_sat_q   <= post_sat_d;
          acc_q       <= '0;
          beat_cnt_q  <= '0;
        end else begin
          acc_q      <= total_d;
          beat_cnt_q <= beat_cnt_q + 1'b1;
        end
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;
  assign bus.busy      = s1_valid_q || (beat_cnt_q != '0);

endmodule

// File: tb/tb_psum_accumulator.sv
// tb/tb_psum_accumulator.sv - self-checking bench for psum_accumulator in three post-processing configurations
module tb_psum_accumulator;
  localparam int DW = 8;
  localparam int NI = 3;
  localparam int AL = 4;
  localparam int OW = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  psum_accumulator_if #(.DATAWIDTH(DW), .NUM_IN(NI), .OUT_WIDTH(OW)) bus_def ();
  psum_accumulator_if #(.DATAWIDTH(DW), .NUM_IN(NI), .OUT_WIDTH(OW)) bus_relu ();
  psum_accumulator_if #(.DATAWIDTH(DW), .NUM_IN(NI), .OUT_WIDTH(OW)) bus_trunc ();

  psum_accumulator #(.DATAWIDTH(DW), .NUM_IN(NI), .ACC_LEN(AL), .OUT_WIDTH(OW),
                     .SAT_EN(1'b1), .RELU_EN(1'b0))
    u_def (.clk(clk), .rst(rst), .bus(bus_def));
  psum_accumulator #(.DATAWIDTH(DW), .NUM_IN(NI), .ACC_LEN(AL), .OUT_WIDTH(OW),
                     .SAT_EN(1'b1), .RELU_EN(1'b1))
    u_relu (.clk(clk), .rst(rst), .bus(bus_relu));
  psum_accumulator #(.DATAWIDTH(DW), .NUM_IN(NI), .ACC_LEN(AL), .OUT_WIDTH(OW),
                     .SAT_EN(1'b0), .RELU_EN(1'b0))
    u_trunc (.clk(clk), .rst(rst), .bus(bus_trunc));

  int checks = 0;
  int errors = 0;

  // Transaction-level model: running group sum and a queue of results due at a given edge.
  typedef struct { int edge_no; int total; } item_t;
  item_t q[$];
  int    edge_no  = 0;
  int    part     = 0;
  int    cnt      = 0;
  bit    beat_now = 0;
  bit    exp_valid = 0;
  bit    busy_exp  = 0;
  bit    started   = 0;
  int    hold_d[3];
  bit    hold_s[3];
  int    last_d[3];
  int    last_s[3];
  int    n_pulse = 0;

  // Config k: 0 = clamp, 1 = ReLU + clamp, 2 = truncate.
  function automatic int post_val(input int k, input int t);
    int x;
    x = t;
    if (k == 1 && x < 0) x = 0;
    if (k == 2) begin
      x = x & ((1 << OW) - 1);
      if (x >= (1 << (OW - 1))) x = x - (1 << OW);
    end else begin
      if (x > (1 << (OW - 1)) - 1) x = (1 << (OW - 1)) - 1;
      if (x < -(1 << (OW - 1)))    x = -(1 << (OW - 1));
    end
    return x;
  endfunction

  function automatic bit post_sat(input int k, input int t);
    int x;
    x = t;
    if (k == 1 && x < 0) x = 0;
    if (k == 2) return 1'b0;
    return (x > (1 << (OW - 1)) - 1) || (x < -(1 << (OW - 1)));
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic chk_dut(input int k, input string nm, input logic v, input int d,
                         input logic s, input logic b);
    chk({nm, " out_valid"}, int'(v), int'(exp_valid));
    chk({nm, " out_data"}, d, hold_d[k]);
    if (exp_valid) chk({nm, " out_sat"}, int'(s), int'(hold_s[k]));
    chk({nm, " busy"}, int'(b), int'(busy_exp));
    if (v === 1'b1) begin
      last_d[k] = d;
      last_s[k] = int'(s);
      if (k == 0) n_pulse++;
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk_dut(0, "def",   bus_def.out_valid,   int'($signed(bus_def.out_data)),   bus_def.out_sat,   bus_def.busy);
      chk_dut(1, "relu",  bus_relu.out_valid,  int'($signed(bus_relu.out_data)),  bus_relu.out_sat,  bus_relu.busy);
      chk_dut(2, "trunc", bus_trunc.out_valid, int'($signed(bus_trunc.out_data)), bus_trunc.out_sat, bus_trunc.busy);
    end
  end

  task automatic model_edge(input bit v, input int a, input int b, input int c,
                            input bit fl, input bit r);
    edge_no++;
    exp_valid = 1'b0;
    if (r) begin
      q.delete();
      part = 0; cnt = 0; beat_now = 1'b0;
      for (int k = 0; k < 3; k++) begin hold_d[k] = 0; hold_s[k] = 1'b0; end
    end else if (fl) begin
      q.delete();
      part = 0; cnt = 0; beat_now = 1'b0;
    end else begin
      if (q.size() > 0 && q[0].edge_no == edge_no) begin
        exp_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
          hold_d[k] = post_val(k, q[0].total);
          hold_s[k] = post_sat(k, q[0].total);
        end
        void'(q.pop_front());
      end
      beat_now = v;
      if (v) begin
        part += a + b + c;
        cnt++;
        if (cnt == AL) begin
          q.push_back('{edge_no + 1, part});
          part = 0;
          cnt  = 0;
        end
      end
    end
    busy_exp = beat_now || (cnt != 0);
  endtask

  task automatic drive(input bit v, input int a, input int b, input int c, input bit fl);
    logic [NI*DW-1:0] d;
    d = {DW'(c), DW'(b), DW'(a)};
    bus_def.in_valid   = v; bus_def.in_data   = d; bus_def.flush   = fl;
    bus_relu.in_valid  = v; bus_relu.in_data  = d; bus_relu.flush  = fl;
    bus_trunc.in_valid = v; bus_trunc.in_data = d; bus_trunc.flush = fl;
  endtask

  task automatic step(input bit v, input int a, input int b, input int c,
                      input bit fl, input bit r);
    drive(v, a, b, c, fl);
    rst = r;
    @(posedge clk);
    model_edge(v, a, b, c, fl, r);
    #1;
  endtask

  task automatic beats(input int n, input int a, input int b, input int c);
    for (int i = 0; i < n; i++) step(1'b1, a, b, c, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, 1'b0, 1'b0);
  endtask

  int p0;

  initial begin
    rst = 1'b1;
    drive(1'b0, 0, 0, 0, 1'b0);
    step(1'b0, 0, 0, 0, 1'b0, 1'b1);
    step(1'b0, 0, 0, 0, 1'b0, 1'b1);
    started = 1'b1;
    chk("reset out_valid", int'(bus_def.out_valid), 0);
    chk("reset out_data",  int'(bus_def.out_data), 0);
    chk("reset out_sat",   int'(bus_def.out_sat), 0);
    chk("reset busy",      int'(bus_def.busy), 0);

    // 4 x (1,2,3) -> 24
    p0 = n_pulse;
    beats(4, 1, 2, 3); idle(3);
    chk("sum24 pulses", n_pulse - p0, 1);
    chk("sum24 data", last_d[0], 24);
    chk("sum24 sat", last_s[0], 0);
    chk("sum24 busy after", int'(bus_def.busy), 0);

    // 4 x (127,127,127) -> 1524: clamp 511, truncate 500
    beats(4, 127, 127, 127); idle(3);
    chk("pos clamp data", last_d[0], 511);
    chk("pos clamp sat", last_s[0], 1);
    chk("pos trunc data", last_d[2], 500);
    chk("pos trunc sat", last_s[2], 0);

    // 4 x (-128,-128,-128) -> -1536: clamp -512, ReLU 0
    beats(4, -128, -128, -128); idle(3);
    chk("neg clamp data", last_d[0], -512);
    chk("neg clamp sat", last_s[0], 1);
    chk("neg relu data", last_d[1], 0);
    chk("neg relu sat", last_s[1], 0);

    // 4 x (-5,1,1) -> -12; ReLU gives 0
    beats(4, -5, 1, 1); idle(3);
    chk("m12 def data", last_d[0], -12);
    chk("m12 relu data", last_d[1], 0);
    chk("m12 relu sat", last_s[1], 0);

    // gapped valid pattern 1,0,0,1,1,0,1 of (1,1,1) -> one output of 12
    p0 = n_pulse;
    step(1, 1, 1, 1, 0, 0); step(0, 0, 0, 0, 0, 0); step(0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 0, 0); step(1, 1, 1, 1, 0, 0); step(0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 0, 0); idle(3);
    chk("gap pulses", n_pulse - p0, 1);
    chk("gap data", last_d[0], 12);

    // 8 continuous beats -> two back-to-back groups
    p0 = n_pulse;
    beats(8, 1, 1, 1); idle(3);
    chk("b2b pulses", n_pulse - p0, 2);

    // flush with a 3rd beat discards the group; the next group sums to 4
    p0 = n_pulse;
    beats(2, 10, 10, 10);
    step(1, 10, 10, 10, 1, 0);
    beats(4, 1, 0, 0); idle(3);
    chk("flush pulses", n_pulse - p0, 1);
    chk("flush data", last_d[0], 4);

    // flush on the edge that would emit the result suppresses the pulse
    p0 = n_pulse;
    beats(4, 1, 1, 1);
    step(0, 0, 0, 0, 1, 0);
    idle(3);
    chk("late flush pulses", n_pulse - p0, 0);
    chk("late flush busy", int'(bus_def.busy), 0);

    // reset mid-group, then a fresh group of (2,2,2) -> 24
    beats(3, 1, 1, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("mid rst out_data", int'(bus_def.out_data), 0);
    chk("mid rst busy", int'(bus_def.busy), 0);
    p0 = n_pulse;
    beats(4, 2, 2, 2); idle(3);
    chk("post rst pulses", n_pulse - p0, 1);
    chk("post rst data", last_d[0], 24);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
